// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, instruction
// field encodings, ALU operation codes and datapath mux select values.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRd,
    StMemWb,
    StMemWr,
    StExecute,
    StAluWb,
    StBranch,
    StAddiExec,
    StAddiWb,
    StJump
  } state_e;

  // Opcodes, instruction bits [31:26]
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // R-type funct codes, instruction bits [5:0]
  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  // ALU operand B select
  localparam logic [1:0] SrcBRegB  = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // Next-PC select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  // True for opcodes that go through the shared address-calculation state.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OpLw) || (op == OpSw);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps an R-type funct field to an ALU operation code and flags whether the
// funct is one the datapath supports.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl_sig,
  output logic       funct_valid
);

  // Pure lookup; unsupported functs fall back to add and are flagged invalid.
  always_comb begin
    alu_ctrl_sig = AluAdd;
    funct_valid  = 1'b1;
    unique case (funct)
      FunctAdd: alu_ctrl_sig = AluAdd;
      FunctSub: alu_ctrl_sig = AluSub;
      FunctAnd: alu_ctrl_sig = AluAnd;
      FunctOr:  alu_ctrl_sig = AluOr;
      FunctSlt: alu_ctrl_sig = AluSlt;
      default:  funct_valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style control FSM for a multicycle MIPS-like datapath with a unified,
// variable-latency memory. Each legal instruction ends with a one-cycle retire
// pulse; undecodable instructions produce a one-cycle illegal pulse in DECODE.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_ctrl_sig,
  output logic       illegal,
  output logic       retire
);

  state_e     state_q, state_d;
  // Remembers lw vs sw from DECODE so MEMADR need not look at the opcode.
  logic       is_store_q, is_store_d;
  logic [2:0] funct_alu;
  logic       funct_valid;

  alu_decoder u_alu_decoder (
    .funct        (funct),
    .alu_ctrl_sig (funct_alu),
    .funct_valid  (funct_valid)
  );

  // State register; reset aborts any in-flight instruction and restarts at FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StFetch;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
    end
  end

  // Next-state and per-state outputs; strobes are forced low while in reset.
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_en        = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SrcBRegB;
    pc_src       = PcSrcAlu;
    alu_ctrl_sig = AluAdd;
    illegal      = 1'b0;
    retire       = 1'b0;

    unique case (state_q)
      StFetch: begin
        // PC+4 is computed every fetch cycle but only committed with the IR.
        mem_req      = 1'b1;
        alu_src_b    = SrcBFour;
        alu_ctrl_sig = AluAdd;
        ir_write     = mem_ready;
        pc_en        = mem_ready;
        if (mem_ready) begin
          state_d = StDecode;
        end
      end

      StDecode: begin
        // Speculative branch target PC + (imm << 2) lands in ALU-out.
        alu_src_b    = SrcBImmSh;
        alu_ctrl_sig = AluAdd;
        is_store_d   = (op == OpSw);
        if (is_mem_op(op)) begin
          state_d = StMemAdr;
        end else begin
          unique case (op)
            OpRtype: begin
              if (funct_valid) begin
                state_d = StExecute;
              end else begin
                illegal = 1'b1;
                state_d = StFetch;
              end
            end
            OpBeq:   state_d = StBranch;
            OpAddi:  state_d = StAddiExec;
            OpJ:     state_d = StJump;
            default: begin
              illegal = 1'b1;
              state_d = StFetch;
            end
          endcase
        end
      end

      StMemAdr: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SrcBImm;
        alu_ctrl_sig = AluAdd;
        state_d      = is_store_q ? StMemWr : StMemRd;
      end

      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end
      end

      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = StFetch;
      end

      StMemWr: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = mem_ready;
        if (mem_ready) begin
          state_d = StFetch;
        end
      end

      StExecute: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SrcBRegB;
        alu_ctrl_sig = funct_alu;
        state_d      = StAluWb;
      end

      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end

      StBranch: begin
        // Compare rs - rt; take the target saved in ALU-out when equal.
        alu_src_a    = 1'b1;
        alu_src_b    = SrcBRegB;
        alu_ctrl_sig = AluSub;
        pc_src       = PcSrcAluOut;
        pc_en        = zero;
        retire       = 1'b1;
        state_d      = StFetch;
      end

      StAddiExec: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SrcBImm;
        alu_ctrl_sig = AluAdd;
        state_d      = StAddiWb;
      end

      StAddiWb: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end

      StJump: begin
        pc_src  = PcSrcJump;
        pc_en   = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end

      default: state_d = StFetch;
    endcase

    // State already reads FETCH during reset; keep its memory request quiet.
    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
      retire    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instruction sequence with a scoreboard.
// Each issued instruction pushes its hand-derived profile; a monitor collects
// per-instruction activity and compares on every retire/illegal pulse.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_en, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl_sig;
  logic       illegal, retire;

  multicycle_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .funct        (funct),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_write    (mem_write),
    .iord         (iord),
    .ir_write     (ir_write),
    .pc_en        (pc_en),
    .reg_write    (reg_write),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .pc_src       (pc_src),
    .alu_ctrl_sig (alu_ctrl_sig),
    .illegal      (illegal),
    .retire       (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected profile of one instruction, from first FETCH cycle to its pulse.
  typedef struct {
    string      name;
    int         cycles;
    logic       ill;
    int         rw;    // cycles with reg_write
    int         mw;    // cycles with mem_write
    int         ir;    // cycles with ir_write
    int         pe;    // cycles with pc_en
    int         mr;    // cycles with mem_req
    logic [1:0] wb;    // {reg_dst, mem_to_reg} seen with reg_write
    logic [1:0] pcs;   // pc_src in final cycle
    logic [2:0] alup;  // alu_ctrl_sig in the cycle before the final one
    logic [2:0] alul;  // alu_ctrl_sig in the final cycle
  } exp_t;

  exp_t sb_q[$];

  function automatic exp_t mk(input string name, input int cycles, input logic ill,
                              input int rw, input int mw, input int ir, input int pe,
                              input int mr, input logic [1:0] wb, input logic [1:0] pcs,
                              input logic [2:0] alup, input logic [2:0] alul);
    exp_t e;
    e.name = name; e.cycles = cycles; e.ill = ill; e.rw = rw; e.mw = mw; e.ir = ir;
    e.pe = pe; e.mr = mr; e.wb = wb; e.pcs = pcs; e.alup = alup; e.alul = alul;
    return e;
  endfunction

  // Monitor accumulators
  int         cyc, nrw, nmw, nir, npe, nmr;
  logic [1:0] wb_seen, pcs_last;
  logic [2:0] alu_prev, alu_last;

  task automatic clear_acc();
    cyc = 0; nrw = 0; nmw = 0; nir = 0; npe = 0; nmr = 0;
    wb_seen = 2'b00; pcs_last = 2'b00; alu_prev = 3'b000; alu_last = 3'b000;
  endtask

  initial begin
    exp_t e;
    clear_acc();
    forever begin
      @(negedge clk);
      if (reset) begin
        clear_acc();
      end else begin
        cyc++;
        if (reg_write) begin
          nrw++;
          wb_seen = {reg_dst, mem_to_reg};
        end
        if (mem_write) nmw++;
        if (ir_write) nir++;
        if (pc_en) npe++;
        if (mem_req) nmr++;
        pcs_last = pc_src;
        alu_prev = alu_last;
        alu_last = alu_ctrl_sig;
        if (retire || illegal) begin
          if (sb_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, retire, illegal}, 32'd0);
          end else begin
            e = sb_q.pop_front();
            check({e.name, ".cycles"}, cyc, e.cycles);
            check({e.name, ".illegal"}, {31'd0, illegal}, {31'd0, e.ill});
            check({e.name, ".retire"}, {31'd0, retire}, {31'd0, ~e.ill});
            check({e.name, ".reg_write_cycles"}, nrw, e.rw);
            check({e.name, ".mem_write_cycles"}, nmw, e.mw);
            check({e.name, ".ir_write_cycles"}, nir, e.ir);
            check({e.name, ".pc_en_cycles"}, npe, e.pe);
            check({e.name, ".mem_req_cycles"}, nmr, e.mr);
            check({e.name, ".wb_sel"}, {30'd0, wb_seen}, {30'd0, e.wb});
            check({e.name, ".pc_src_last"}, {30'd0, pcs_last}, {30'd0, e.pcs});
            check({e.name, ".alu_prev"}, {29'd0, alu_prev}, {29'd0, e.alup});
            check({e.name, ".alu_last"}, {29'd0, alu_last}, {29'd0, e.alul});
          end
          clear_acc();
        end
      end
    end
  end

  // Drives n cycles: f FETCH wait cycles, then mem_ready ignored-pattern
  // (low in DECODE and the following state), then m memory wait cycles.
  task automatic drive_cycles(input logic [5:0] op_v, input logic [5:0] funct_v,
                              input logic zero_v, input int f, input int m, input int n);
    for (int c = 1; c <= n; c++) begin
      op    = op_v;
      funct = funct_v;
      zero  = zero_v;
      if (c <= f)              mem_ready = 1'b0;
      else if (c == f + 1)     mem_ready = 1'b1;
      else if (c <= f + 3 + m) mem_ready = 1'b0;
      else                     mem_ready = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input logic [5:0] op_v, input logic [5:0] funct_v,
                           input logic zero_v, input int f, input int m, input exp_t e);
    sb_q.push_back(e);
    drive_cycles(op_v, funct_v, zero_v, f, m, e.cycles);
  endtask

  task automatic check_reset_quiet(input string tag);
    check({tag, ".mem_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, ".mem_write"}, {31'd0, mem_write}, 32'd0);
    check({tag, ".ir_write"}, {31'd0, ir_write}, 32'd0);
    check({tag, ".pc_en"}, {31'd0, pc_en}, 32'd0);
    check({tag, ".reg_write"}, {31'd0, reg_write}, 32'd0);
    check({tag, ".illegal"}, {31'd0, illegal}, 32'd0);
    check({tag, ".retire"}, {31'd0, retire}, 32'd0);
  endtask

  localparam logic [5:0] FunctNone = 6'b111111;

  initial begin
    reset     = 1'b1;
    op        = 6'd0;
    funct     = 6'd0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    #2;
    check_reset_quiet("por");
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("por_release.mem_req", {31'd0, mem_req}, 32'd1);
    check("por_release.iord", {31'd0, iord}, 32'd0);
    check("por_release.alu_src_b", {30'd0, alu_src_b}, 32'd1);
    check("por_release.alu_ctrl", {29'd0, alu_ctrl_sig}, 32'd2);

    run_instr(OpLw, FunctNone, 1'b0, 0, 3,
              mk("lw_wait", 8, 0, 1, 0, 1, 1, 5, 2'b01, 2'b00, AluAdd, AluAdd));
    run_instr(OpRtype, FunctSub, 1'b0, 0, 0,
              mk("r_sub", 4, 0, 1, 0, 1, 1, 1, 2'b10, 2'b00, AluSub, AluAdd));
    run_instr(OpBeq, FunctNone, 1'b1, 0, 0,
              mk("beq_taken", 3, 0, 0, 0, 1, 2, 1, 2'b00, 2'b01, AluAdd, AluSub));
    run_instr(OpBeq, FunctNone, 1'b0, 0, 0,
              mk("beq_not", 3, 0, 0, 0, 1, 1, 1, 2'b00, 2'b01, AluAdd, AluSub));
    run_instr(6'b111111, FunctNone, 1'b0, 0, 0,
              mk("ill_op", 2, 1, 0, 0, 1, 1, 1, 2'b00, 2'b00, AluAdd, AluAdd));
    run_instr(OpRtype, 6'b000111, 1'b0, 0, 0,
              mk("ill_funct", 2, 1, 0, 0, 1, 1, 1, 2'b00, 2'b00, AluAdd, AluAdd));
    run_instr(OpSw, FunctNone, 1'b0, 0, 0,
              mk("sw", 4, 0, 0, 1, 1, 1, 2, 2'b00, 2'b00, AluAdd, AluAdd));
    run_instr(OpAddi, FunctNone, 1'b0, 0, 0,
              mk("addi", 4, 0, 1, 0, 1, 1, 1, 2'b00, 2'b00, AluAdd, AluAdd));
    run_instr(OpJ, FunctNone, 1'b0, 0, 0,
              mk("jump", 3, 0, 0, 0, 1, 2, 1, 2'b00, 2'b10, AluAdd, AluAdd));
    run_instr(OpRtype, FunctAdd, 1'b0, 2, 0,
              mk("r_add_fwait", 6, 0, 1, 0, 1, 1, 3, 2'b10, 2'b00, AluAdd, AluAdd));
    run_instr(OpRtype, FunctAnd, 1'b0, 0, 0,
              mk("r_and", 4, 0, 1, 0, 1, 1, 1, 2'b10, 2'b00, AluAnd, AluAdd));
    run_instr(OpRtype, FunctOr, 1'b0, 0, 0,
              mk("r_or", 4, 0, 1, 0, 1, 1, 1, 2'b10, 2'b00, AluOr, AluAdd));
    run_instr(OpRtype, FunctSlt, 1'b0, 0, 0,
              mk("r_slt", 4, 0, 1, 0, 1, 1, 1, 2'b10, 2'b00, AluSlt, AluAdd));
    run_instr(OpLw, FunctNone, 1'b0, 0, 0,
              mk("lw_fast", 5, 0, 1, 0, 1, 1, 2, 2'b01, 2'b00, AluAdd, AluAdd));

    // Abort an lw while it waits in MEMRD; it must never retire.
    drive_cycles(OpLw, FunctNone, 1'b0, 0, 10, 4);
    mem_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_reset_quiet("abort");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_release.mem_req", {31'd0, mem_req}, 32'd1);
    check("abort_release.iord", {31'd0, iord}, 32'd0);
    run_instr(OpAddi, FunctNone, 1'b0, 0, 0,
              mk("addi_after_abort", 4, 0, 1, 0, 1, 1, 1, 2'b00, 2'b00, AluAdd, AluAdd));

    // Park in FETCH with no memory response so nothing else can retire.
    mem_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pending_expectations", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: none; opcodes, funct codes and ALU codes come from the shared package.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  instruction register bits [31:26].
REQ-005 funct  input  6  instruction register bits [5:0].
REQ-006 zero  input  1  ALU zero flag from datapath.
REQ-007 mem_ready  input  1  unified memory completes current access this cycle.
REQ-008 mem_req / mem_write  output  1 / 1  memory access request / write qualifier.
REQ-009 iord  output  1  0 = memory address from PC, 1 = from ALU-out register.
REQ-010 ir_write, pc_en, reg_write  output  1 each  register enables.
REQ-011 reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath mux selects.
REQ-012 alu_src_b  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-013 pc_src  output  2  00 ALU result, 01 ALU-out register, 10 jump target.
REQ-014 alu_ctrl_sig  output  3  ALU operation code.
REQ-015 illegal  output  1  one-cycle pulse on undecodable instruction.
REQ-016 retire  output  1  one-cycle pulse on the final cycle of each legal instruction.

Function
REQ-017 Moore FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
REQ-018 FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl_sig=010; ir_write=pc_en=mem_ready; stay in FETCH until mem_ready=1, then DECODE.
REQ-019 DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl_sig=010; next by op: lw/sw->MEMADR, R->EXECUTE, beq->BRANCH, addi->ADDIEXEC, j->JUMP.
REQ-020 DECODE with unknown op, or op=R with funct not in {add, sub, and, or, slt}: illegal=1 for that cycle, no enables asserted, next FETCH.
REQ-021 MEMADR: alu_src_a=1, alu_src_b=10, alu_ctrl_sig=010; next MEMRD (lw) or MEMWR (sw).
REQ-022 MEMRD: mem_req=1, iord=1; hold until mem_ready, then MEMWB.
REQ-023 MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, retire=1; next FETCH.
REQ-024 MEMWR: mem_req=1, mem_write=1, iord=1; hold until mem_ready; retire=mem_ready; then FETCH.
REQ-025 EXECUTE: alu_src_a=1, alu_src_b=00, alu_ctrl_sig from funct: add 010, sub 110, and 000, or 001, slt 111; next ALUWB.
REQ-026 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1; next FETCH.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl_sig=110, pc_src=01, pc_en=zero, retire=1; next FETCH.
REQ-028 ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_ctrl_sig=010; next ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, retire=1; next FETCH.
REQ-029 JUMP: pc_src=10, pc_en=1, retire=1; next FETCH.
REQ-030 Every output not listed for a state is 0; alu_ctrl_sig defaults to 010.
REQ-031 mem_ready outside FETCH/MEMRD/MEMWR is ignored; outputs and transitions do not depend on it.
REQ-032 op and funct are sampled only in DECODE/EXECUTE; the IR is stable there because ir_write is 0.
REQ-033 Cycle counts with mem_ready=1 every cycle: lw 5, sw 4, R 4, addi 4, beq 3, j 3; each memory wait cycle adds one.

Reset
REQ-034 Asserting reset asynchronously forces state to FETCH, mid-instruction included; the aborted instruction never retires.
REQ-035 While reset=1, all enable and strobe outputs (mem_req, mem_write, ir_write, pc_en, reg_write, illegal, retire) are 0.
REQ-036 First FETCH access is issued on the first rising edge after reset deasserts.

Structure
REQ-037 Shared package holds the state enum, the opcode constants (lw 100011, sw 101011, R 000000, beq 000100, addi 001000, j 000010), the funct constants and the ALU code constants.
REQ-038 One sub-module, alu_decoder (funct in, alu_ctrl_sig and funct_valid out, combinational), is instantiated by the FSM.

Verification
REQ-039 Reset mid-MEMRD, release: next cycle is FETCH with mem_req=1, iord=0; no retire pulse for the aborted lw.
REQ-040 lw (op 100011), mem_ready held 0 for 3 cycles in MEMRD -> MEMRD lasts 4 cycles; reg_write=1 with mem_to_reg=1 in MEMWB; retire once, 8 cycles total.
REQ-041 R-type sub (funct 100010) -> alu_ctrl_sig=110 in EXECUTE; reg_write=1 with reg_dst=1 in ALUWB; 4 cycles.
REQ-042 beq with zero=1, then with zero=0 -> pc_en=1 vs pc_en=0 in BRANCH, pc_src=01 in both; 3 cycles each.
REQ-043 op 111111, then R-type funct 000111 -> illegal=1 one cycle in DECODE, no reg_write or mem_write, FETCH next cycle.
REQ-044 sw with mem_ready=1 immediately -> mem_write=1 for exactly one cycle, retire coincident, 4 cycles.
